spike_input_scheduler: RTL

Transmitter side of the network processor's input-spike handshake. Accepts timestamped external spike events into a FIFO, tracks network time, and drives `input_occurred`/`input_index` toward the network processor once each event's timestamp is due, holding the request until `input_ack`. It sits between the host/stimulus interface and the network processor's input port.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/spike_input_scheduler_event_fifo.sv | 54 +++++
 rtl/spike_input_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking-network input path.
package snn_pkg;

  localparam int unsigned DEFAULT_SR_DEPTH   = 16384;
  localparam int unsigned DEFAULT_TIME_WIDTH = 16;
  localparam int unsigned DEFAULT_IDX_WIDTH  = $clog2(DEFAULT_SR_DEPTH);

  // Buffered input spike: synapse-row index plus the timestep it is due.
  // The FIFO word is laid out the same way (index in the upper bits).
  typedef struct packed {
    logic [DEFAULT_IDX_WIDTH-1:0]  index;
    logic [DEFAULT_TIME_WIDTH-1:0] timestamp;
  } spike_event_t;

  // Transmit-side handshake states toward the network processor.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } spike_tx_state_e;

endpackage

// File: rtl/spike_input_scheduler_event_fifo.sv
// event_fifo: synchronous FIFO with occupancy count, async active-low reset.
// DEPTH must be a power of two so pointers wrap naturally.
module event_fifo #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count as is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_input_scheduler.sv
// spike_input_scheduler: buffers timestamped host spikes and presents each to
// the network processor once network time reaches its timestamp, holding
// input_occurred until input_ack. Optional macro SPIKE_DROP_COUNT_EN adds a
// saturating drop_count of rejected host pushes.
module spike_input_scheduler
  import snn_pkg::*;
#(
  parameter int unsigned SR_DEPTH   = DEFAULT_SR_DEPTH,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIME_WIDTH = DEFAULT_TIME_WIDTH,
  localparam int unsigned IDX_W     = $clog2(SR_DEPTH),
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_index,
  input  logic [TIME_WIDTH-1:0] in_time,
  input  logic                  tick,
  output logic                  input_occurred,
  output logic [IDX_W-1:0]      input_index,
  input  logic                  input_ack,
  output logic [TIME_WIDTH-1:0] time_now,
  output logic [CNT_W-1:0]      fifo_count
`ifdef SPIKE_DROP_COUNT_EN
  ,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned WORD_W = IDX_W + TIME_WIDTH;

  spike_tx_state_e        state;
  spike_tx_state_e        state_next;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WORD_W-1:0]      head_word;
  logic [IDX_W-1:0]       head_index;
  logic [TIME_WIDTH-1:0]  head_time;
  logic [TIME_WIDTH-1:0]  time_diff;
  logic                   head_due;

  // fifo_full is decoded purely from the occupancy count, so in_ready has no
  // path from in_valid.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  event_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_index, in_time}),
    .rdata (head_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_index = head_word[WORD_W-1:TIME_WIDTH];
  assign head_time  = head_word[TIME_WIDTH-1:0];

  // Modular distance to the head timestamp: zero means now, MSB set means the
  // timestamp is in the past (within half the time range), so both dispatch.
  assign time_diff = head_time - time_now;
  assign head_due  = (time_diff == '0) || time_diff[TIME_WIDTH-1];

  // Network time counter, wrapping at 2^TIME_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    time_now <= '0;
    else if (tick) time_now <= time_now + TIME_WIDTH'(1);
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state, FIFO pop and request output for the handshake.
  always_comb begin
    state_next     = state;
    pop            = 1'b0;
    input_occurred = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && head_due) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        input_occurred = 1'b1;
        if (input_ack) state_next = ST_GAP;
      end
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the head index as it is popped; held stable through SEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   input_index <= '0;
    else if (pop) input_index <= head_index;
  end

`ifdef SPIKE_DROP_COUNT_EN
  // Saturating count of cycles where the host offered an event to a full FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_count <= '0;
    else if (in_valid && !in_ready && (drop_count != '1))
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule
